// File: rtl/arm_rf_pkg.sv
// Shared definitions for the ARM-style register file with load scoreboard.
// Default geometry: 16 registers of 32 bits, with register 15 reading as the PC.
// reg_idx_t and word_t are sized for that default geometry.
package arm_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;
  localparam int PC_IDX_DEF = 15;
  localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/arm_rf_scoreboard.sv
// Load scoreboard for the register file.
// It tracks one busy bit per register between a load issue and its port-B return.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   ra1..ra3, re1..re3  read addresses and read-valids; these only feed the stall
//   we_a, wa_a        port-A write enable and index; used for WAW error detection
//   we_b, wa_b        port-B write enable and index; any port-B write clears busy
//   ld_issue, ld_dst  load issue strobe and destination register
//   busy              registered scoreboard vector
//   stall             combinational hazard flag
//   waw_err           sticky flag: port A wrote a register that has a load outstanding
//
// Handshake: ld_issue acts as a valid signal, and !stall acts as its ready.
// A load is accepted only in a cycle where ld_issue && !stall. In every other
// cycle the issuer must hold ld_issue and ld_dst unchanged.
module arm_rf_scoreboard
  import arm_rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int PC_IDX = NREGS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  input  logic              re1,
  input  logic              re2,
  input  logic              re3,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  output logic [NREGS-1:0]  busy,
  output logic              stall,
  output logic              waw_err
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;

  // A register still counts as pending unless its load returns in this same
  // cycle. Port B bypasses to readers, so the returning value is already usable.
  function automatic logic pending(input logic [NREGS-1:0]  b,
                                   input logic [NREGS-1:0]  c,
                                   input logic [ADDR_W-1:0] idx);
    return (idx != PC_ADDR) && b[idx] && !c[idx];
  endfunction

  always_comb begin
    clr = '0;
    if (we_b) clr[wa_b] = 1'b1;
  end

  // The last term covers load-after-load to a register that is still busy.
  always_comb begin
    stall = (re1      && pending(busy, clr, ra1))
         || (re2      && pending(busy, clr, ra2))
         || (re3      && pending(busy, clr, ra3))
         || (ld_issue && pending(busy, clr, ld_dst));
  end

  always_comb begin
    set = '0;
    if (ld_issue && !stall && (ld_dst != PC_ADDR)) set[ld_dst] = 1'b1;
  end

  // Set is applied after clear, so a new load can be issued in the same
  // cycle that the previous load to that register returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      busy    <= (busy & ~clr) | set;
      waw_err <= waw_err | (we_a && pending(busy, clr, wa_a));
    end
  end

endmodule

// File: rtl/arm_regfile_sb.sv
// Register file with two write ports, three combinational read ports,
// same-cycle write bypass, a live PC read, and a load scoreboard.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   ra1..ra3 / rd1..rd3 read addresses and combinational read data
//   re1..re3            read-valids; these only qualify the stall
//   pc_in               value returned when a read addresses PC_IDX
//   we_a, wa_a, wd_a    write port A (ALU writeback)
//   we_b, wa_b, wd_b    write port B (load return); wins over A on the same index
//   ld_issue, ld_dst    load issue and destination register
//   busy, stall, waw_err  scoreboard outputs
module arm_regfile_sb
  import arm_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int PC_IDX = NREGS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  input  logic              re1,
  input  logic              re2,
  input  logic              re3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  output logic [NREGS-1:0]  busy,
  output logic              stall,
  output logic              waw_err
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] ra_v [3];
  logic [DATA_W-1:0] rd_v [3];

  // The PC slot is never written. Its storage stays at reset value and is
  // never read, because reads of PC_IDX return pc_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i != PC_IDX) begin
          if (we_b && (wa_b == ADDR_W'(i)))      regs[i] <= wd_b;
          else if (we_a && (wa_a == ADDR_W'(i))) regs[i] <= wd_a;
        end
      end
    end
  end

  assign ra_v[0] = ra1;
  assign ra_v[1] = ra2;
  assign ra_v[2] = ra3;

  // Per-port read priority: PC, then port B bypass, then port A bypass, then storage.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_v[k] = regs[ra_v[k]];
      if (ra_v[k] == PC_ADDR)                 rd_v[k] = pc_in;
      else if (we_b && (wa_b == ra_v[k]))     rd_v[k] = wd_b;
      else if (we_a && (wa_a == ra_v[k]))     rd_v[k] = wd_a;
    end
  end

  assign rd1 = rd_v[0];
  assign rd2 = rd_v[1];
  assign rd3 = rd_v[2];

  arm_rf_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .ra1      (ra1),
    .ra2      (ra2),
    .ra3      (ra3),
    .re1      (re1),
    .re2      (re2),
    .re3      (re3),
    .we_a     (we_a),
    .wa_a     (wa_a),
    .we_b     (we_b),
    .wa_b     (wa_b),
    .ld_issue (ld_issue),
    .ld_dst   (ld_dst),
    .busy     (busy),
    .stall    (stall),
    .waw_err  (waw_err)
  );

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed testbench for arm_regfile_sb.
// Expected values are computed by hand from the register-file and scoreboard rules.
module tb_arm_regfile_sb;
  import arm_rf_pkg::*;

  logic     clk;
  logic     reset;
  reg_idx_t ra1, ra2, ra3;
  logic     re1, re2, re3;
  word_t    rd1, rd2, rd3;
  word_t    pc_in;
  logic     we_a, we_b, ld_issue;
  reg_idx_t wa_a, wa_b, ld_dst;
  word_t    wd_a, wd_b;
  logic [NREGS_DEF-1:0] busy;
  logic     stall, waw_err;

  int n_cmp;
  int n_err;

  arm_regfile_sb dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .re1(re1), .re2(re2), .re3(re3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .pc_in(pc_in),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ld_issue(ld_issue), .ld_dst(ld_dst),
    .busy(busy), .stall(stall), .waw_err(waw_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_a = 0; wa_a = '0; wd_a = '0;
    we_b = 0; wa_b = '0; wd_b = '0;
    ld_issue = 0; ld_dst = '0;
    re1 = 0; re2 = 0; re3 = 0;
  endtask

  task automatic test_reset();
    reset = 1; pc_in = 32'h0000_1000;
    ra1 = '0; ra2 = '0; ra3 = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    for (int r = 0; r < 15; r++) begin
      ra1 = reg_idx_t'(r);
      #1;
      n_cmp++;
      if (rd1 !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rd R%0d: got %h expected %h", r, rd1, 32'h0);
      end
    end
    ra1 = 4'd15;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0000_1000) begin
      n_err++; $display("FAIL reset_pc: got %h expected %h", rd1, 32'h0000_1000);
    end
    n_cmp++;
    if (busy !== 16'h0 || waw_err !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_sb: busy=%h waw=%b stall=%b expected 0/0/0", busy, waw_err, stall);
    end
  endtask

  task automatic test_write_bypass();
    we_a = 1; wa_a = 4'd3; wd_a = 32'hAAAA_0003; ra1 = 4'd3;
    #1;
    n_cmp++;
    if (rd1 !== 32'hAAAA_0003) begin
      n_err++; $display("FAIL bypass_a: got %h expected %h", rd1, 32'hAAAA_0003);
    end
    step();
    we_a = 0;
    #1;
    n_cmp++;
    if (rd1 !== 32'hAAAA_0003) begin
      n_err++; $display("FAIL stored_a: got %h expected %h", rd1, 32'hAAAA_0003);
    end
    // Both ports write R3: port B wins on the bypass path and in storage.
    we_a = 1; wa_a = 4'd3; wd_a = 32'h1111_1111;
    we_b = 1; wa_b = 4'd3; wd_b = 32'h0000_BBBB;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0000_BBBB) begin
      n_err++; $display("FAIL bypass_prio: got %h expected %h", rd1, 32'h0000_BBBB);
    end
    step();
    we_a = 0; we_b = 0;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0000_BBBB) begin
      n_err++; $display("FAIL stored_prio: got %h expected %h", rd1, 32'h0000_BBBB);
    end
    // Two different indices written in one cycle: both commit.
    we_a = 1; wa_a = 4'd4; wd_a = 32'h4444_0004;
    we_b = 1; wa_b = 4'd6; wd_b = 32'h6666_0006;
    step();
    we_a = 0; we_b = 0;
    ra2 = 4'd4; ra3 = 4'd6;
    #1;
    n_cmp++;
    if (rd2 !== 32'h4444_0004 || rd3 !== 32'h6666_0006) begin
      n_err++; $display("FAIL dual_write: got %h/%h expected %h/%h", rd2, rd3, 32'h4444_0004, 32'h6666_0006);
    end
  endtask

  task automatic test_raw();
    ld_issue = 1; ld_dst = 4'd5;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL raw_issue_stall: got %b expected 0", stall);
    end
    step();
    ld_issue = 0;
    #1;
    n_cmp++;
    if (busy !== 16'h0020) begin
      n_err++; $display("FAIL raw_busy_set: got %h expected %h", busy, 16'h0020);
    end
    re2 = 1; ra2 = 4'd5;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL raw_stall: got %b expected 1", stall);
    end
    // While R5 is busy, an invalid read does not stall.
    re2 = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL raw_re_qual: got %b expected 0", stall);
    end
    re2 = 1;
    we_b = 1; wa_b = 4'd5; wd_b = 32'h0000_0055;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || rd2 !== 32'h0000_0055) begin
      n_err++; $display("FAIL raw_return: stall=%b rd2=%h expected 0/%h", stall, rd2, 32'h55);
    end
    step();
    we_b = 0;
    #1;
    n_cmp++;
    if (busy !== 16'h0 || rd2 !== 32'h0000_0055 || stall !== 1'b0) begin
      n_err++; $display("FAIL raw_after: busy=%h rd2=%h stall=%b expected 0/%h/0", busy, rd2, stall, 32'h55);
    end
    re2 = 0;
  endtask

  task automatic test_load_after_load();
    ld_issue = 1; ld_dst = 4'd7;
    step();
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL lal_stall: got %b expected 1", stall);
    end
    step();
    n_cmp++;
    if (busy !== 16'h0080) begin
      n_err++; $display("FAIL lal_busy_hold: got %h expected %h", busy, 16'h0080);
    end
    // The old load returns while the new load issues: no stall, busy stays set.
    we_b = 1; wa_b = 4'd7; wd_b = 32'h0000_0077;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL lal_ret_stall: got %b expected 0", stall);
    end
    step();
    ld_issue = 0; we_b = 0;
    ra1 = 4'd7;
    #1;
    n_cmp++;
    if (busy !== 16'h0080 || rd1 !== 32'h0000_0077) begin
      n_err++; $display("FAIL lal_setclr: busy=%h rd1=%h expected %h/%h", busy, rd1, 16'h0080, 32'h77);
    end
    we_b = 1; wa_b = 4'd7; wd_b = 32'h0000_0777;
    step();
    we_b = 0;
    #1;
    n_cmp++;
    if (busy !== 16'h0) begin
      n_err++; $display("FAIL lal_drain: got %h expected 0", busy);
    end
  endtask

  task automatic test_waw_pc();
    ld_issue = 1; ld_dst = 4'd9;
    step();
    ld_issue = 0;
    we_a = 1; wa_a = 4'd9; wd_a = 32'h0000_0099;
    #1;
    n_cmp++;
    if (waw_err !== 1'b0) begin
      n_err++; $display("FAIL waw_early: got %b expected 0", waw_err);
    end
    step();
    we_a = 0; ra1 = 4'd9;
    #1;
    n_cmp++;
    if (waw_err !== 1'b1 || busy !== 16'h0200 || rd1 !== 32'h0000_0099) begin
      n_err++; $display("FAIL waw_set: waw=%b busy=%h rd1=%h expected 1/%h/%h", waw_err, busy, rd1, 16'h0200, 32'h99);
    end
    step();
    n_cmp++;
    if (waw_err !== 1'b1) begin
      n_err++; $display("FAIL waw_sticky: got %b expected 1", waw_err);
    end
    // The PC index is never written and never made busy.
    pc_in = 32'h0000_2000;
    we_a = 1; wa_a = 4'd15; wd_a = 32'hDEAD_0000;
    we_b = 1; wa_b = 4'd15; wd_b = 32'hBEEF_0000;
    ld_issue = 1; ld_dst = 4'd15; ra1 = 4'd15; re1 = 1;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0000_2000 || stall !== 1'b0) begin
      n_err++; $display("FAIL pc_read: rd1=%h stall=%b expected %h/0", rd1, stall, 32'h2000);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (busy !== 16'h0200 || rd1 !== 32'h0000_2000 || waw_err !== 1'b1) begin
      n_err++; $display("FAIL pc_protect: busy=%h rd1=%h waw=%b expected %h/%h/1", busy, rd1, waw_err, 16'h0200, 32'h2000);
    end
  endtask

  task automatic test_async_reset();
    ld_issue = 1; ld_dst = 4'd5;
    we_a = 1; wa_a = 4'd1; wd_a = 32'h0000_1234;
    step();
    idle_inputs();
    ra1 = 4'd1; ra2 = 4'd15;
    #1;
    n_cmp++;
    if (busy !== 16'h0220 || rd1 !== 32'h0000_1234 || waw_err !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: busy=%h rd1=%h waw=%b expected %h/%h/1", busy, rd1, waw_err, 16'h0220, 32'h1234);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if (busy !== 16'h0 || waw_err !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0000_2000) begin
      n_err++; $display("FAIL async_reset: busy=%h waw=%b rd1=%h rd2=%h expected 0/0/0/%h", busy, waw_err, rd1, rd2, 32'h2000);
    end
    step();
    reset = 0;
    step();
    n_cmp++;
    if (busy !== 16'h0 || rd1 !== 32'h0) begin
      n_err++; $display("FAIL post_reset: busy=%h rd1=%h expected 0/0", busy, rd1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_bypass();
    test_raw();
    test_load_after_load();
    test_waw_pc();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arm_regfile_sb.md
Name: arm_regfile_sb

Overview:
- Parametrised successor to the core register file.
- Two write ports: A for ALU/execute writeback, B for load/memory writeback.
- Three read ports: Rn, Rm, Rs.
- PC-index reads return the live PC; same-cycle writes are bypassed to readers.
- A load scoreboard produces a stall for the hazard unit between decode and writeback.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 16, number of architectural registers (power of 2, ≥4).
- ADDR_W, $clog2(NREGS), register index width.
- PC_IDX, NREGS-1, index that reads as pc_in; it is never written.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ra1, ra2, ra3  in  ADDR_W  read addresses
- re1, re2, re3  in  1  read-valid, qualifies stall only
- rd1, rd2, rd3  out  DATA_W  read data, combinational
- pc_in  in  DATA_W  value returned for PC_IDX reads (PC+8)
- we_a, wa_a, wd_a  in  1/ADDR_W/DATA_W  write port A (ALU)
- we_b, wa_b, wd_b  in  1/ADDR_W/DATA_W  write port B (load return)
- ld_issue  in  1  load issued this cycle
- ld_dst  in  ADDR_W  load destination register
- busy  out  NREGS  scoreboard vector, registered
- stall  out  1  hazard detected, combinational
- waw_err  out  1  sticky error: port A wrote a register with an outstanding load

Behaviour:
- Reset (asynchronous, may assert mid-operation): all registers = 0, busy = 0, waw_err = 0 immediately. rd* then equals pc_in for PC_IDX and 0 otherwise. Any pending loads are discarded.
- Writes:
  - Committed on posedge clk.
  - Both ports writing the same index: port B wins.
  - Writes to PC_IDX are dropped, no error.
- Reads (combinational, zero latency), priority order per port:
  1. ra == PC_IDX → pc_in
  2. we_b && wa_b == ra → wd_b
  3. we_a && wa_a == ra → wd_a
  4. otherwise stored value
- clr_i = we_b && wa_b == i (any port-B write clears busy; no separate tag).
- hit_k = re_k && ra_k != PC_IDX && busy[ra_k] && !clr[ra_k].
- stall = OR(hit_1..3) OR (ld_issue && ld_dst != PC_IDX && busy[ld_dst] && !clr[ld_dst]). The last term is the WAW load-after-load hazard.
- Busy update on posedge:
  - busy[i] <= (busy[i] && !clr_i) || set_i.
  - set_i = ld_issue && !stall && ld_dst == i && i != PC_IDX.
  - Set beats clear on the same index in the same cycle (a new load after the old one returns).
  - ld_issue while stall is asserted has no effect; the issuer must hold it.
- waw_err:
  - Set on posedge when we_a && wa_a != PC_IDX && busy[wa_a] && !clr[wa_a].
  - The port-A write still commits.
  - Cleared only by reset.
- No internal state depends on re*; stall is purely combinational from busy and inputs.

Decomposition:
- Package arm_rf_pkg holds:
  - DATA_W_DEF = 32, NREGS_DEF = 16, PC_IDX_DEF = 15
  - typedef reg_idx_t (logic [ADDR_W-1:0])
  - typedef word_t (logic [DATA_W-1:0])
- One sub-module, arm_rf_scoreboard, owns busy, the set/clear logic, stall and waw_err.
- The top level holds the storage array, write arbitration and the bypass muxes.

Test Plan:
- Reset, then read R0..R14 with pc_in = 0x1000 → all 0; ra1 = 15 → rd1 = 0x1000.
- Write, bypass and port priority:
  - we_a = 1, wa_a = 3, wd_a = 0xAAAA_0003 with ra1 = 3 → rd1 = 0xAAAA_0003 in the same cycle, and still after the edge.
  - Same cycle we_b to R3 with 0xBBBB → rd1 = 0xBBBB and stored value = 0xBBBB.
- Scoreboard RAW:
  - ld_issue to R5 → busy[5] = 1 next cycle; re2 = 1, ra2 = 5 → stall = 1.
  - Cycle with we_b to R5 = 0x55 → stall = 0, rd2 = 0x55, busy[5] = 0 after the edge.
- Load-after-load and same-cycle set/clear:
  - R7 busy, ld_issue R7 without we_b → stall = 1, busy unchanged.
  - With we_b to R7 in that cycle → stall = 0, busy[7] remains 1.
- WAW error and PC protection:
  - R9 busy, we_a to R9 = 0x99 → waw_err = 1 (sticky), R9 = 0x99, busy[9] still 1.
  - we_a/we_b to R15 and ld_issue R15 → no state change, busy[15] = 0.
- Asynchronous reset mid-operation: with busy = 0x0220 and waw_err = 1, assert reset between edges → busy = 0, waw_err = 0, R1 = 0 immediately, before the next clk.
